// File: rtl/pipe_hazard_ctrl.sv
// Freeze/flush sequencer for the 5-stage ARM pipeline: memory wait > branch flush > hazard bubble.
// Optional saturating performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 hazard_detected,
   input  logic                 branch_taken,
   input  logic                 mem_req,
   input  logic                 sram_ready,
   output logic                 pc_freeze,
   output logic                 if_freeze,
   output logic                 if_flush,
   output logic                 id_freeze,
   output logic                 id_flush,
   output logic                 exe_freeze,
   output logic [CNT_WIDTH-1:0] stall_cycles,
   output logic [CNT_WIDTH-1:0] flush_count
);

   typedef enum logic {
      IDLE,
      MEM_WAIT
   } state_t;

   state_t state, state_nxt;
   logic   br_pend, br_pend_nxt;
   logic   branch_any;

   // Strobes are combinational so a stall takes effect in the cycle its condition appears.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      pc_freeze   = 1'b0;
      if_freeze   = 1'b0;
      if_flush    = 1'b0;
      id_freeze   = 1'b0;
      id_flush    = 1'b0;
      exe_freeze  = 1'b0;
      state_nxt   = state;
      br_pend_nxt = br_pend;
      branch_any  = branch_taken | br_pend;

      if (!rst) begin
         case (state)
            IDLE: begin
               if (mem_req && !sram_ready) begin
                  pc_freeze  = 1'b1;
                  if_freeze  = 1'b1;
                  id_freeze  = 1'b1;
                  exe_freeze = 1'b1;
                  state_nxt  = MEM_WAIT;
                  if (branch_taken) br_pend_nxt = 1'b1;
               end else if (branch_any) begin
                  if_flush    = 1'b1;
                  id_flush    = 1'b1;
                  br_pend_nxt = 1'b0;
               end else if (hazard_detected) begin
                  pc_freeze = 1'b1;
                  if_freeze = 1'b1;
                  id_flush  = 1'b1;
               end
            end
            MEM_WAIT: begin
               if (!sram_ready) begin
                  pc_freeze  = 1'b1;
                  if_freeze  = 1'b1;
                  id_freeze  = 1'b1;
                  exe_freeze = 1'b1;
                  if (branch_taken) br_pend_nxt = 1'b1;
               end else begin
                  // Release cycle: a branch remembered during the wait is flushed now.
                  state_nxt   = IDLE;
                  br_pend_nxt = 1'b0;
                  if (branch_any) begin
                     if_flush = 1'b1;
                     id_flush = 1'b1;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) begin
         state   <= IDLE;
         br_pend <= 1'b0;
      end else begin
         state   <= state_nxt;
         br_pend <= br_pend_nxt;
      end
   end

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] stall_q, flush_q;
   logic                 any_freeze;

   assign any_freeze = pc_freeze | if_freeze | id_freeze | exe_freeze;

   // Both counters saturate at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (any_freeze && (stall_q != '1)) stall_q <= stall_q + CNT_WIDTH'(1);
         if (if_flush && (flush_q != '1))   flush_q <= flush_q + CNT_WIDTH'(1);
      end
   end

   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule
